mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly after the execute stage and before writeback. It latches the execute-stage result bundle and captures the synchronous data-SRAM read word for loads, holding it stable across writeback back-pressure. Loaded bytes and halfwords are aligned and extended here. It produces the final register-write value and the IDU forwarding/hazard information.

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_load_align.sv | 20 ++
 rtl/mem_stage.sv | 65 ++++++
 tb/tb_mem_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: load opcodes and pass-signal widths shared by the memory stage
package mem_stage_pkg;
    localparam int PASS_IN_W  = 7;
    localparam int PASS_OUT_W = 6;
    localparam logic [9:0] LD_B  = 10'h0A0;
    localparam logic [9:0] LD_H  = 10'h0A1;
    localparam logic [9:0] LD_W  = 10'h0A2;
    localparam logic [9:0] LD_BU = 10'h0A8;
    localparam logic [9:0] LD_HU = 10'h0A9;
    typedef logic [PASS_IN_W-1:0]  pass_in_t;
    typedef logic [PASS_OUT_W-1:0] pass_out_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-side inputs, writeback/IDU-side outputs and SRAM read data of the memory stage
interface mem_stage_if;
    import mem_stage_pkg::*;
    logic             EXU_to_MEM_valid;
    logic             MEM_allow_in;
    logic             WB_allow_in;
    logic             MEM_to_WB_valid;
    logic [31:0]      EXU_pc_to_MEM;
    logic [31:0]      EXU_inst_to_MEM;
    logic [31:0]      EXU_result_to_MEM;
    pass_in_t         EXU_signals_pass_to_MEM;
    logic [31:0]      data_sram_rdata;
    logic [31:0]      MEM_pc_to_WB;
    logic [31:0]      MEM_inst_to_WB;
    logic [31:0]      MEM_final_result_to_WB;
    pass_out_t        MEM_signals_pass_to_WB;
    logic             MEM_to_IDU_gr_we;
    logic [4:0]       MEM_to_IDU_dest;
    logic             MEM_to_IDU_valid;
    logic [31:0]      MEM_to_IDU_forward;
    modport slave (
        input  EXU_to_MEM_valid, WB_allow_in, EXU_pc_to_MEM, EXU_inst_to_MEM,
               EXU_result_to_MEM, EXU_signals_pass_to_MEM, data_sram_rdata,
        output MEM_allow_in, MEM_to_WB_valid, MEM_pc_to_WB, MEM_inst_to_WB,
               MEM_final_result_to_WB, MEM_signals_pass_to_WB, MEM_to_IDU_gr_we,
               MEM_to_IDU_dest, MEM_to_IDU_valid, MEM_to_IDU_forward
    );
    modport master (
        output EXU_to_MEM_valid, WB_allow_in, EXU_pc_to_MEM, EXU_inst_to_MEM,
               EXU_result_to_MEM, EXU_signals_pass_to_MEM, data_sram_rdata,
        input  MEM_allow_in, MEM_to_WB_valid, MEM_pc_to_WB, MEM_inst_to_WB,
               MEM_final_result_to_WB, MEM_signals_pass_to_WB, MEM_to_IDU_gr_we,
               MEM_to_IDU_dest, MEM_to_IDU_valid, MEM_to_IDU_forward
    );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: byte/halfword extraction and sign/zero extension of a loaded word
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [1:0]  off,
    input  logic [9:0]  opcode,
    output logic [31:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b   = load_word[{off, 3'b000} +: 8];
        h   = load_word[{off[1], 4'b0000} +: 16];
        ext = opcode == LD_B  ? {{24{b[7]}}, b}  :
              opcode == LD_BU ? {24'h0, b}       :
              opcode == LD_H  ? {{16{h[15]}}, h} :
              opcode == LD_HU ? {16'h0, h}       : load_word;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; sub-word load extension enabled by MEM_SUBWORD_LOAD_EN
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    mem_stage_if.slave bus
);
    logic        valid_q, valid_d, first_q, first_d, accept;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, result_q, result_d, hold_q, hold_d;
    logic [31:0] load_word, load_ext, final_result;
    pass_in_t    sig_q, sig_d;
    assign bus.MEM_allow_in = !valid_q || bus.WB_allow_in;
    assign accept           = bus.MEM_allow_in && bus.EXU_to_MEM_valid;
    // The SRAM port already shows the next address while stalled, so reuse the captured word
    assign load_word        = first_q ? bus.data_sram_rdata : hold_q;
    always_comb begin
        valid_d  = bus.MEM_allow_in ? bus.EXU_to_MEM_valid : valid_q;
        first_d  = accept;
        pc_d     = accept ? bus.EXU_pc_to_MEM : pc_q;
        inst_d   = accept ? bus.EXU_inst_to_MEM : inst_q;
        result_d = accept ? bus.EXU_result_to_MEM : result_q;
        sig_d    = accept ? bus.EXU_signals_pass_to_MEM : sig_q;
        hold_d   = first_q ? bus.data_sram_rdata : hold_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            result_q <= '0;
            sig_q    <= '0;
            hold_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            first_q  <= first_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            result_q <= result_d;
            sig_q    <= sig_d;
            hold_q   <= hold_d;
        end
    end
`ifdef MEM_SUBWORD_LOAD_EN
    mem_load_align u_align (
        .load_word(load_word),
        .off      (result_q[1:0]),
        .opcode   (inst_q[31:22]),
        .ext      (load_ext)
    );
`else
    assign load_ext = load_word;
`endif
    assign final_result               = sig_q[6] ? load_ext : result_q;
    assign bus.MEM_to_WB_valid        = valid_q;
    assign bus.MEM_pc_to_WB           = pc_q;
    assign bus.MEM_inst_to_WB         = inst_q;
    assign bus.MEM_final_result_to_WB = final_result;
    assign bus.MEM_signals_pass_to_WB = sig_q[5:0];
    assign bus.MEM_to_IDU_gr_we       = sig_q[5] && valid_q;
    assign bus.MEM_to_IDU_dest        = sig_q[4:0];
    assign bus.MEM_to_IDU_valid       = valid_q;
    assign bus.MEM_to_IDU_forward     = final_result;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of the memory stage handshake, load alignment, stall hold and reset
module tb_mem_stage;
    import mem_stage_pkg::*;
    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    mem_stage_if bus();
    mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  op;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic [31:0] exp_sub;
    } ld_vec_t;
    ld_vec_t vecs [9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] res, input logic [6:0] sig);
        bus.EXU_to_MEM_valid        = 1'b1;
        bus.EXU_pc_to_MEM           = pc;
        bus.EXU_inst_to_MEM         = inst;
        bus.EXU_result_to_MEM       = res;
        bus.EXU_signals_pass_to_MEM = sig;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ld_exp(input logic [31:0] sub, input logic [31:0] raw);
`ifdef MEM_SUBWORD_LOAD_EN
        return sub;
`else
        return raw;
`endif
    endfunction

    initial begin
        vecs[0] = '{LD_B,   2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF};
        vecs[1] = '{LD_BU,  2'd2, 32'h80FF_7F01, 32'h0000_00FF};
        vecs[2] = '{LD_B,   2'd1, 32'h80FF_7F01, 32'h0000_007F};
        vecs[3] = '{LD_B,   2'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
        vecs[4] = '{LD_H,   2'd2, 32'h8001_0000, 32'hFFFF_8001};
        vecs[5] = '{LD_HU,  2'd2, 32'h8001_0000, 32'h0000_8001};
        vecs[6] = '{LD_H,   2'd3, 32'h8001_0000, 32'hFFFF_8001};
        vecs[7] = '{LD_W,   2'd0, 32'h8001_0000, 32'h8001_0000};
        vecs[8] = '{10'h004, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01};

        resetn = 1'b0;
        bus.EXU_to_MEM_valid = 1'b0;
        bus.WB_allow_in = 1'b1;
        bus.EXU_pc_to_MEM = '0;
        bus.EXU_inst_to_MEM = '0;
        bus.EXU_result_to_MEM = '0;
        bus.EXU_signals_pass_to_MEM = '0;
        bus.data_sram_rdata = 32'hA5A5_A5A5;
        #12;
        check("rst_valid", bus.MEM_to_WB_valid, 0);
        check("rst_allow", bus.MEM_allow_in, 1);
        check("rst_final", bus.MEM_final_result_to_WB, 0);
        check("rst_pass", bus.MEM_signals_pass_to_WB, 0);
        check("rst_idu_valid", bus.MEM_to_IDU_valid, 0);
        check("rst_pc", bus.MEM_pc_to_WB, 0);
        resetn = 1'b1;

        // ALU passthrough
        offer(32'h0000_1000, 32'h0010_0000, 32'h1234_5678, {1'b0, 1'b1, 5'd5});
        tick;
        bus.EXU_to_MEM_valid = 1'b0;
        #1;
        check("alu_valid", bus.MEM_to_WB_valid, 1);
        check("alu_final", bus.MEM_final_result_to_WB, 32'h1234_5678);
        check("alu_pass", bus.MEM_signals_pass_to_WB, 6'h25);
        check("alu_gr_we", bus.MEM_to_IDU_gr_we, 1);
        check("alu_dest", bus.MEM_to_IDU_dest, 5);
        check("alu_fwd", bus.MEM_to_IDU_forward, 32'h1234_5678);
        check("alu_pc", bus.MEM_pc_to_WB, 32'h0000_1000);
        check("alu_inst", bus.MEM_inst_to_WB, 32'h0010_0000);

        // load alignment table, back-to-back
        for (int i = 0; i < 9; i++) begin
            offer(32'h0000_2000 + 32'(i * 4), {vecs[i].op, 22'h0}, {30'h0400_0000, vecs[i].off}, {1'b1, 1'b1, 5'd7});
            tick;
            bus.EXU_to_MEM_valid = 1'b0;
            bus.data_sram_rdata = vecs[i].rdata;
            #1;
            check($sformatf("ld%0d_final", i), bus.MEM_final_result_to_WB, ld_exp(vecs[i].exp_sub, vecs[i].rdata));
            check($sformatf("ld%0d_valid", i), bus.MEM_to_WB_valid, 1);
        end
        tick;
        check("drain_valid", bus.MEM_to_WB_valid, 0);

        // load stalled by writeback; a waiting instruction replaces it when released
        bus.WB_allow_in = 1'b0;
        offer(32'h0000_3000, {LD_W, 22'h0}, 32'h0000_0100, {1'b1, 1'b1, 5'd9});
        tick;
        bus.data_sram_rdata = 32'h1234_5678;
        offer(32'h0000_3004, 32'h0010_0000, 32'hAAAA_0000, {1'b0, 1'b1, 5'd10});
        #1;
        check("stall_first", bus.MEM_final_result_to_WB, 32'h1234_5678);
        check("stall_allow0", bus.MEM_allow_in, 0);
        for (int c = 0; c < 3; c++) begin
            tick;
            bus.data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            check($sformatf("stall%0d_final", c), bus.MEM_final_result_to_WB, 32'h1234_5678);
            check($sformatf("stall%0d_allow", c), bus.MEM_allow_in, 0);
            check($sformatf("stall%0d_pc", c), bus.MEM_pc_to_WB, 32'h0000_3000);
        end
        bus.WB_allow_in = 1'b1;
        #1;
        check("release_allow", bus.MEM_allow_in, 1);
        tick;
        bus.EXU_to_MEM_valid = 1'b0;
        #1;
        check("replace_pc", bus.MEM_pc_to_WB, 32'h0000_3004);
        check("replace_final", bus.MEM_final_result_to_WB, 32'hAAAA_0000);
        check("replace_dest", bus.MEM_to_IDU_dest, 10);
        tick;

        // back-to-back load, add, load
        offer(32'h0000_4000, {LD_W, 22'h0}, 32'h0000_0200, {1'b1, 1'b1, 5'd1});
        tick;
        bus.data_sram_rdata = 32'h1111_1111;
        offer(32'h0000_4004, 32'h0010_0000, 32'h2222_2222, {1'b0, 1'b1, 5'd2});
        #1;
        check("b2b0_fwd", bus.MEM_to_IDU_forward, 32'h1111_1111);
        check("b2b0_valid", bus.MEM_to_WB_valid, 1);
        tick;
        bus.data_sram_rdata = 32'h9999_9999;
        offer(32'h0000_4008, {LD_H, 22'h0}, 32'h0000_0300, {1'b1, 1'b1, 5'd3});
        #1;
        check("b2b1_fwd", bus.MEM_to_IDU_forward, 32'h2222_2222);
        check("b2b1_pc", bus.MEM_pc_to_WB, 32'h0000_4004);
        check("b2b1_valid", bus.MEM_to_WB_valid, 1);
        tick;
        bus.EXU_to_MEM_valid = 1'b0;
        bus.data_sram_rdata = 32'h0000_8765;
        #1;
        check("b2b2_fwd", bus.MEM_to_IDU_forward, ld_exp(32'hFFFF_8765, 32'h0000_8765));
        check("b2b2_dest", bus.MEM_to_IDU_dest, 3);
        check("b2b2_valid", bus.MEM_to_WB_valid, 1);
        tick;
        check("b2b_empty", bus.MEM_to_WB_valid, 0);

        // reset asserted mid-stall
        bus.WB_allow_in = 1'b0;
        offer(32'h0000_5000, {LD_W, 22'h0}, 32'h0000_0400, {1'b1, 1'b1, 5'd4});
        tick;
        bus.EXU_to_MEM_valid = 1'b0;
        #1;
        check("pre_rst_gr_we", bus.MEM_to_IDU_gr_we, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", bus.MEM_to_WB_valid, 0);
        check("arst_gr_we", bus.MEM_to_IDU_gr_we, 0);
        check("arst_allow", bus.MEM_allow_in, 1);
        check("arst_final", bus.MEM_final_result_to_WB, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick;
        check("post_rst_valid", bus.MEM_to_WB_valid, 0);
        check("post_rst_idu_valid", bus.MEM_to_IDU_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
